// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl: sample counting, stage enables, rate changes and start-up valid suppression for a CIC decimator
module cic_decim_ctrl #(
  parameter int RW = 8,
  parameter int STAGES = 3,
  parameter int DEF_RATE = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_enable,
  input  logic          i_ce,
  input  logic [RW-1:0] i_rate,
  input  logic          i_rate_load,
  output logic          o_int_ce,
  output logic          o_comb_ce,
  output logic          o_clear,
  output logic          o_out_valid,
  output logic [RW-1:0] o_rate,
  output logic [RW-1:0] o_phase,
  output logic [1:0]    o_state,
  output logic          o_rate_err
);
  localparam int FW = $clog2(STAGES + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;
  state_t state;
  logic [RW-1:0] pend_rate;
  logic pend;
  logic [FW-1:0] fill;
  logic [STAGES-1:0] vp;
  logic bnd, tag;
  assign bnd = i_ce && (o_phase == o_rate - RW'(1));
  assign tag = bnd && !pend && state == RUN;
  assign o_state = state;
  // A boundary with a pending rate swaps the rate and clears the datapath instead of emitting the sample
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      pend_rate <= '0;
      pend <= 1'b0;
      fill <= '0;
      vp <= '0;
      o_int_ce <= 1'b0;
      o_comb_ce <= 1'b0;
      o_clear <= 1'b0;
      o_out_valid <= 1'b0;
      o_rate <= RW'(DEF_RATE);
      o_phase <= '0;
      o_rate_err <= 1'b0;
    end else begin
      o_rate_err <= i_rate_load && i_rate == '0;
      o_clear <= 1'b0;
      o_int_ce <= 1'b0;
      o_comb_ce <= 1'b0;
      if (state == IDLE && pend) begin
        o_rate <= pend_rate;
        pend <= 1'b0;
      end
      if (!i_enable) begin
        state <= IDLE;
        o_phase <= '0;
        fill <= '0;
        vp <= '0;
        o_out_valid <= 1'b0;
      end else if (state == IDLE) begin
        state <= FILL;
        o_clear <= 1'b1;
      end else begin
        vp <= (vp << 1) | STAGES'(tag);
        o_out_valid <= vp[STAGES-1];
        if (i_ce) o_phase <= bnd ? '0 : o_phase + 1'b1;
        if (bnd && pend) begin
          o_rate <= pend_rate;
          pend <= 1'b0;
          state <= FILL;
          fill <= '0;
          o_clear <= 1'b1;
        end else begin
          o_int_ce <= i_ce;
          o_comb_ce <= bnd;
          if (bnd && state == FILL) begin
            state <= (fill == FW'(STAGES - 1)) ? RUN : FILL;
            fill <= (fill == FW'(STAGES - 1)) ? '0 : fill + 1'b1;
          end
        end
      end
      if (i_rate_load && i_rate != '0) begin
        pend_rate <= i_rate;
        pend <= 1'b1;
      end
    end
endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb_cic_decim_ctrl: directed checks of enables, fill suppression, rate changes, enable drop and reset
module tb_cic_decim_ctrl;
  logic i_clk = 1'b0, i_reset = 1'b1, i_enable = 1'b0, i_ce = 1'b0, i_rate_load = 1'b0;
  logic [7:0] i_rate = '0;
  logic o_int_ce, o_comb_ce, o_clear, o_out_valid, o_rate_err;
  logic [7:0] o_rate, o_phase;
  logic [1:0] o_state;
  int checks = 0, failures = 0, idx = 0;
  logic [63:0] comb_m, int_m, clr_m, val_m;
  logic phase_nz;
  cic_decim_ctrl #(.RW(8), .STAGES(3), .DEF_RATE(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_ce(i_ce),
    .i_rate(i_rate), .i_rate_load(i_rate_load), .o_int_ce(o_int_ce),
    .o_comb_ce(o_comb_ce), .o_clear(o_clear), .o_out_valid(o_out_valid),
    .o_rate(o_rate), .o_phase(o_phase), .o_state(o_state), .o_rate_err(o_rate_err)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    idx = 0;
    comb_m = '0;
    int_m = '0;
    clr_m = '0;
    val_m = '0;
    phase_nz = 1'b0;
  endtask
  task automatic step();
    @(posedge i_clk);
    #1;
    idx++;
    if (idx < 64) begin
      comb_m[idx[5:0]] = o_comb_ce;
      int_m[idx[5:0]] = o_int_ce;
      clr_m[idx[5:0]] = o_clear;
      val_m[idx[5:0]] = o_out_valid;
    end
    if (o_phase != 0) phase_nz = 1'b1;
  endtask
  initial begin
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    chk("rst_state", 64'(o_state), 0);
    chk("rst_rate", 64'(o_rate), 8);
    chk("rst_phase", 64'(o_phase), 0);
    chk("rst_bits", {o_int_ce, o_comb_ce, o_clear, o_out_valid, o_rate_err}, 0);
    // start-up at rate 8 with back-to-back strobes
    clr();
    i_enable = 1'b1;
    i_ce = 1'b1;
    repeat (40) step();
    chk("s1_clear", clr_m, 64'd1 << 1);
    chk("s1_comb", comb_m, (64'd1 << 9) | (64'd1 << 17) | (64'd1 << 25) | (64'd1 << 33));
    chk("s1_valid", val_m, 64'd1 << 36);
    chk("s1_int", int_m, {23'd0, {39{1'b1}}, 2'b00});
    chk("s1_phase", 64'(o_phase), 7);
    chk("s1_state", 64'(o_state), 2);
    // load rate 5 at phase 3
    clr();
    for (int i = 1; i <= 34; i++) begin
      i_rate_load = (i == 5);
      i_rate = 8'd5;
      step();
    end
    i_rate_load = 1'b0;
    chk("s2_clear", clr_m, 64'd1 << 9);
    chk("s2_comb", comb_m, (64'd1 << 1) | (64'd1 << 14) | (64'd1 << 19) | (64'd1 << 24) | (64'd1 << 29) | (64'd1 << 34));
    chk("s2_valid", val_m, (64'd1 << 4) | (64'd1 << 32));
    chk("s2_int", int_m, ((64'd1 << 35) - 64'd2) & ~(64'd1 << 9));
    chk("s2_rate", 64'(o_rate), 5);
    // load on a boundary, then overwrite before apply
    clr();
    for (int i = 1; i <= 22; i++) begin
      i_rate_load = (i == 5) || (i == 7);
      i_rate = (i == 5) ? 8'd7 : 8'd3;
      step();
      if (i == 9) chk("s3_rate_hold", 64'(o_rate), 5);
    end
    i_rate_load = 1'b0;
    chk("s3_clear", clr_m, 64'd1 << 10);
    chk("s3_comb", comb_m, (64'd1 << 5) | (64'd1 << 13) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22));
    chk("s3_valid", val_m, (64'd1 << 3) | (64'd1 << 8));
    chk("s3_rate", 64'(o_rate), 3);
    // zero rate is rejected
    clr();
    i_rate = 8'd0;
    i_rate_load = 1'b1;
    step();
    chk("s4_err", 64'(o_rate_err), 1);
    i_rate_load = 1'b0;
    step();
    chk("s4_err_pulse", 64'(o_rate_err), 0);
    repeat (8) step();
    chk("s4_no_clear", clr_m, 0);
    chk("s4_rate", 64'(o_rate), 3);
    // drop enable with a tagged comb pulse in flight
    begin
      int n = 0;
      while (!o_comb_ce && n < 10) begin
        step();
        n++;
      end
    end
    chk("s5_comb_seen", 64'(o_comb_ce), 1);
    clr();
    i_enable = 1'b0;
    step();
    chk("s5_state", 64'(o_state), 0);
    chk("s5_phase", 64'(o_phase), 0);
    repeat (5) step();
    chk("s5_valid", val_m, 0);
    chk("s5_rate", 64'(o_rate), 3);
    // rate 1 loaded in IDLE, strobes every other cycle
    i_rate = 8'd1;
    i_rate_load = 1'b1;
    step();
    i_rate_load = 1'b0;
    chk("s6_rate_pre", 64'(o_rate), 3);
    step();
    chk("s6_rate", 64'(o_rate), 1);
    clr();
    i_enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      i_ce = (i % 2 == 0);
      step();
    end
    chk("s6_int", int_m, 64'h155554);
    chk("s6_comb", comb_m, 64'h155554);
    chk("s6_clear", clr_m, 64'd2);
    chk("s6_phase", 64'(phase_nz), 0);
    // asynchronous reset mid-period
    i_ce = 1'b1;
    i_rate = 8'd6;
    for (int i = 1; i <= 10; i++) begin
      i_rate_load = (i == 1);
      step();
    end
    i_rate_load = 1'b0;
    chk("s7_phase_pre", 64'(o_phase), 2);
    chk("s7_rate_pre", 64'(o_rate), 6);
    #2 i_reset = 1'b1;
    #1;
    chk("s7_state", 64'(o_state), 0);
    chk("s7_phase", 64'(o_phase), 0);
    chk("s7_rate", 64'(o_rate), 8);
    chk("s7_bits", {o_int_ce, o_comb_ce, o_clear, o_out_valid, o_rate_err}, 0);
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    clr();
    repeat (6) step();
    chk("s7_valid", val_m, 0);
    chk("s7_restart", clr_m, 64'd2);
    chk("s7_rate_after", 64'(o_rate), 8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cic_decim_ctrl.md
# cic_decim_ctrl

Sequencing controller for the CIC decimator chain: counts input sample strobes, generates the integrator-section and comb-section clock enables at the programmed decimation rate, and manages runtime rate changes. It also suppresses the invalid start-up outputs while the comb delay lines fill. It sits between the upstream sample source and the integrator/comb stage cascade. Its enables drive the stages' `i_ce` inputs, and its valid output qualifies the final comb output.

## Interface
- `RW`, default 8: width of the decimation-rate register and phase counter.
- `STAGES`, default 3: number of cascaded comb stages driven by `o_comb_ce`.
- `DEF_RATE`, default 8: decimation rate loaded at reset. Must be in 1..2^RW-1.
- `i_clk`, input, 1: system clock. All state is updated on the rising edge.
- `i_reset`, input, 1: asynchronous, active-high reset.
- `i_enable`, input, 1: run request. Low holds the chain idle.
- `i_ce`, input, 1: input sample strobe, one cycle per sample.
- `i_rate`, input, RW: requested decimation rate.
- `i_rate_load`, input, 1: single-cycle strobe that captures `i_rate`.
- `o_int_ce`, output, 1: integrator-section enable.
- `o_comb_ce`, output, 1: comb-section enable, asserted once per decimated sample.
- `o_clear`, output, 1: single-cycle pulse that clears the datapath delay lines and accumulators.
- `o_out_valid`, output, 1: the final comb stage output is a valid decimated sample.
- `o_rate`, output, RW: currently active rate.
- `o_phase`, output, RW: current input count within the decimation period, 0..rate-1.
- `o_state`, output, 2: state code. IDLE=0, FILL=1, RUN=2.
- `o_rate_err`, output, 1: single-cycle pulse flagging a rejected rate load.

## Operation
- State IDLE:
  - The phase counter is held at 0.
  - No enables or valids are issued.
  - Moves to FILL on the first cycle `i_enable`=1.
  - On that transition `o_clear` pulses for one cycle.
- State FILL:
  - Enables are issued as in RUN.
  - A fill counter counts `o_comb_ce` pulses.
  - Moves to RUN after the STAGES-th `o_comb_ce`.
  - `o_out_valid` is suppressed for every decimated sample produced in FILL.
- State RUN:
  - Normal operation.
  - Moves back to FILL when a pending rate is applied. This also pulses `o_clear` and resets the fill counter.
- Any state goes to IDLE when `i_enable`=0. The transition takes effect on the next edge.
- IDLE entry does the following:
  - clears the phase counter and the fill counter;
  - clears the valid delay pipeline, so no `o_out_valid` fires after `i_enable` drops;
  - keeps any pending rate.
- Phase counter:
  - Increments on each `i_ce` while not IDLE.
  - The decimation boundary is an `i_ce` arriving while the phase is at rate-1. On a boundary the phase wraps to 0 and `o_comb_ce` is issued.
  - With rate=1, every `i_ce` is a boundary.
- Rate load:
  - `i_rate_load` with `i_rate`>=1 writes the pending register and sets a pending flag.
  - A second load before apply overwrites the first.
  - `i_rate`=0 is rejected: the pending state is unchanged and `o_rate_err` pulses.
- Rate apply:
  - In IDLE, a pending rate is applied on the cycle after the load.
  - Otherwise it is applied at the first boundary occurring in a cycle after the load. A load in the same cycle as a boundary waits for the following boundary.
  - On apply, `o_rate` updates and the phase restarts at 0 under the new rate.
- Reset values:
  - All single-bit outputs are 0.
  - `o_phase`=0, `o_state`=IDLE, `o_rate`=DEF_RATE.
  - The pending flag, fill counter and valid pipeline are cleared.

## Timing
- All outputs are registered.
- `o_int_ce` is `i_ce` delayed by exactly 1 cycle while not IDLE.
- `o_comb_ce` is asserted in the same cycle as the `o_int_ce` of the boundary sample.
- `o_out_valid` is the `o_comb_ce` pulse delayed by STAGES cycles, matching one register per comb stage. It is gated by a per-pulse tag that records whether the pulse was issued in RUN.
- `o_clear` is asserted 1 cycle after the enabling edge or after the apply boundary. In the cycle it is high, `o_int_ce` and `o_comb_ce` are 0.
- `o_rate`, `o_phase` and `o_state` update on the same edge as the event that changes them.
- Back-to-back `i_ce` (every cycle) is supported with no lost strobes.
- Asynchronous reset mid-operation returns all outputs to their reset values immediately. The controller restarts from IDLE.

## Test plan
- Reset, then `i_enable`=1 with `i_ce` every cycle at rate 8:
  - `o_clear` pulses once;
  - `o_comb_ce` pulses every 8 cycles;
  - the first 3 decimated samples have no `o_out_valid`;
  - the 4th has `o_out_valid` exactly 3 cycles after its `o_comb_ce`.
- Rate 1 with `i_ce` every other cycle: `o_comb_ce` equals `o_int_ce` and `o_phase` stays 0.
- In RUN, load rate 5 at phase 3 of rate 8:
  - the current period completes at 8;
  - `o_clear` pulses and `o_rate`=5;
  - subsequent periods are 5 inputs long;
  - FILL is re-entered with 3 suppressed valids.
- Load coincident with a boundary: the rate is applied at the following boundary, not the current one. A second load of 3 before apply results in `o_rate`=3.
- `i_rate_load` with `i_rate`=0: `o_rate_err` pulses for one cycle and the active and pending rates are unchanged.
- Drop `i_enable` while a comb pulse is in the valid pipeline, and separately assert `i_reset` mid-period:
  - no `o_out_valid` appears;
  - `o_state`=0, `o_phase`=0;
  - `o_rate` holds the current value after the `i_enable` drop and is `DEF_RATE` after reset.
